// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory and loads the IF/ID register.
// Optional macro ALIGN_CHECK_EN adds a sticky flag for misaligned branch targets.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        oob_fault,
  output logic        align_fault
);

  localparam logic [31:0] LAST_PC = IMEM_BYTES - 4;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_p0, pc_p0_d;
  logic [31:0] pc_p1, pc_p1_d;
  logic [31:0] instr_p1, instr_p1_d;
  logic        vld_p1, vld_p1_d;
  logic        oob_q, oob_d;
  logic [31:0] target;
  logic [31:0] pc_inc;
  logic        target_ok;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  assign target    = word_align(branch_addr);
  assign target_ok = (target <= LAST_PC);
  assign pc_inc    = pc_p0 + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_p0_d     = pc_p0;
    pc_p1_d     = pc_p1;
    instr_p1_d  = instr_p1;
    vld_p1_d    = vld_p1;
    oob_d       = oob_q;
    if (branch_taken) begin
      // A redirect always flushes IF/ID, even while frozen or halted
      pc_p1_d    = '0;
      instr_p1_d = '0;
      vld_p1_d   = 1'b0;
      if (target_ok) begin
        pc_p0_d = target;
        state_d = RUN;
        oob_d   = 1'b0;
      end else begin
        state_d = HALT;
        oob_d   = 1'b1;
      end
    end else begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (!freeze) begin
            pc_p1_d    = pc_inc;
            instr_p1_d = imem_instr;
            vld_p1_d   = 1'b1;
            // The last word is still latched; the PC parks on it
            if (pc_p0 >= LAST_PC) begin
              state_d = HALT;
              oob_d   = 1'b1;
            end else begin
              pc_p0_d = pc_inc;
            end
          end
        end
        HALT: begin
          pc_p1_d    = '0;
          instr_p1_d = '0;
          vld_p1_d   = 1'b0;
        end
        default: state_d = BOOT;
      endcase
    end
  end

  // Stage p0 -> p1: PC register and IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_p0    <= RESET_PC;
      pc_p1    <= '0;
      instr_p1 <= '0;
      vld_p1   <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_p0    <= pc_p0_d;
      pc_p1    <= pc_p1_d;
      instr_p1 <= instr_p1_d;
      vld_p1   <= vld_p1_d;
      oob_q    <= oob_d;
    end
  end

  assign imem_addr = pc_p0;
  assign if_pc     = pc_p1;
  assign if_instr  = instr_p1;
  assign if_valid  = vld_p1;
  assign oob_fault = oob_q;

`ifdef ALIGN_CHECK_EN
  logic align_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      align_q <= 1'b0;
    end else if (branch_taken && (branch_addr[1:0] != 2'b00)) begin
      align_q <= 1'b1;
    end
  end

  assign align_fault = align_q;
`else
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^branch_addr[1:0];
  assign align_fault      = 1'b0;
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage that drives the byte-addressed, little-endian, combinational-read instruction memory and consumes the 32-bit word it returns.
- Owns the PC. Handles sequential fetch, hazard freeze, branch redirect and out-of-range halt.
- Registers the fetched instruction plus PC+4 into the IF/ID pipeline register feeding decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset. Must be word aligned.
- IMEM_BYTES, 1024, instruction memory size in bytes. The last legal fetch address is IMEM_BYTES-4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- freeze  input  1  hazard stall: hold the PC and the IF/ID register
- branch_taken  input  1  redirect request from the execute stage
- branch_addr  input  32  byte address of the branch target
- imem_addr  output  32  fetch address to instruction memory; equals the PC
- imem_instr  input  32  word returned combinationally for imem_addr
- if_pc  output  32  registered PC+4 of the instruction held in IF/ID
- if_instr  output  32  registered instruction
- if_valid  output  1  IF/ID register holds a real instruction
- oob_fault  output  1  sticky flag: PC left the memory range
- align_fault  output  1  misaligned branch target seen (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: PC=RESET_PC, if_pc=0, if_instr=0, if_valid=0, oob_fault=0, align_fault=0, state=BOOT.
- imem_addr is the PC register directly. No combinational path from any input to imem_addr.
- Latency: the word at address A appears on if_instr, with if_pc=A+4 and if_valid=1, on the edge after which PC==A. One cycle total.
- States:
  - BOOT: lasts exactly one cycle after reset. if_valid stays 0 and PC holds. Goes to RUN unconditionally, unless branch_taken is high (branch is applied, then RUN).
  - RUN: normal fetch.
  - HALT: entered when the next PC would exceed IMEM_BYTES-4.
- Per-edge priority in RUN: rst > branch_taken > freeze > sequential.
  - branch_taken: PC<=target; IF/ID flushed (if_instr=0, if_valid=0, if_pc=0). Branch overrides freeze.
  - freeze (no branch): PC and all IF/ID outputs hold their values.
  - Sequential: IF/ID<={PC+4, imem_instr, 1}; PC<=PC+4.
- Arithmetic: PC+4 is a 32-bit add; wrap at 2^32 is unreachable because HALT triggers first.
- HALT entry: in RUN, when PC==IMEM_BYTES-4 and a sequential advance occurs, the last word is still latched normally. Then state<=HALT and oob_fault<=1.
- In HALT:
  - PC holds at IMEM_BYTES-4; no further fetch.
  - IF/ID: if_valid=0 from the following edge; if_instr=0, if_pc=0.
  - freeze has no effect.
- Leaving HALT: branch_taken with an in-range target (target <= IMEM_BYTES-4) sets PC=target, state<=RUN, oob_fault<=0.
- Out-of-range branch target (any state): PC unchanged, IF/ID flushed, state<=HALT, oob_fault<=1.
- Reset mid-operation: rst overrides everything, including a simultaneous branch and any HALT state.
- Flush and freeze in the same cycle: flush wins. if_valid=0 after the edge.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- With ALIGN_CHECK_EN defined:
  - A taken branch with branch_addr[1:0]!=0 sets sticky align_fault<=1.
  - The target is forced to {branch_addr[31:2],2'b00}.
  - align_fault clears only on rst.
- Without ALIGN_CHECK_EN:
  - branch_addr[1:0] are ignored silently; target={branch_addr[31:2],2'b00}.
  - align_fault is tied 0.

Test Plan:
- Reset and sequential fetch. Memory holds 0xE3A00014 at 0, 0xE3A01A01 at 4, 0xE3A02103 at 8. Stimulus: rst for 2 cycles, then release. Required:
  - 1 BOOT cycle with if_valid=0.
  - Then (if_pc, if_instr) = (4, E3A00014), (8, E3A01A01), (12, E3A02103) on consecutive cycles.
  - imem_addr=0,4,8,12.
- Freeze. Assert freeze for 3 cycles while PC=16. Required: imem_addr stays 16 and IF/ID stays (16, word@12) for all 3 cycles. Fetch resumes with (20, word@16).
- Branch during freeze. At PC=24, freeze=1 and branch_taken=1 with branch_addr=100. Required:
  - Next cycle: if_valid=0, if_instr=0, imem_addr=100.
  - Following cycle: (104, word@100), if_valid=1.
- End of memory. Branch to 1016 and run freely. Required:
  - (1020, word@1016), then (1024, word@1020).
  - Then if_valid=0, oob_fault=1, imem_addr held at 1020.
  - A branch to 0 clears oob_fault and fetch resumes at 0.
- Out-of-range target. branch_addr=2048. Required: state HALT, oob_fault=1, IF/ID flushed, PC unchanged.
- Misaligned target. branch_addr=0x42. Required:
  - Both builds: PC=0x40.
  - align_fault=1 with ALIGN_CHECK_EN, 0 without.
  - rst clears align_fault.
